// File: rtl/booth_pkg.sv
// Shared definitions for the Booth operand feeder: operand width, FSM encoding
// and watchdog limit.
package booth_pkg;

  localparam int OP_W = 16;
  localparam int WD_W = 7;
  localparam logic [WD_W-1:0] WD_LIMIT = 7'd96;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    LOAD_M    = 3'd2,
    LOAD_Q    = 3'd3,
    WAIT_DONE = 3'd4,
    WAIT_CLR  = 3'd5
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0] mcand;
    logic [OP_W-1:0] mplier;
  } operand_pair_t;

endpackage

// File: rtl/booth_watchdog.sv
// Saturating watchdog counter: cleared when a job launches, counts while the
// feeder waits for the multiplier, flags when the limit is reached.
module booth_watchdog
  import booth_pkg::*;
#(
  parameter logic [WD_W-1:0] LIMIT = WD_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_hit
);

  logic [WD_W-1:0] r_count;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; blocking assignments here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_hit) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_hit = (r_count == LIMIT);

endmodule

// File: rtl/booth_operand_feeder.sv
// Feeds operand pairs to a Booth multiplier over a shared bus: start pulse,
// multiplicand, multiplier, then waits for done. Define BOOTH_FEED_SKID_EN for a 1-entry skid buffer.
module booth_operand_feeder
  import booth_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  input  logic [OP_W-1:0] s_mcand,
  input  logic [OP_W-1:0] s_mplier,
  output logic            s_ready,
  output logic            start,
  output logic [OP_W-1:0] data_in,
  input  logic            mult_done,
  output logic            job_done,
  output logic            timeout,
  output logic            busy
);

  state_t        r_state;
  state_t        w_next;
  operand_pair_t r_op;
  operand_pair_t w_in_pair;
  operand_pair_t w_launch_pair;
  logic          w_launch;
  logic          w_wd_hit;
  logic          w_job_done_set;
  logic          w_timeout_set;
  logic          r_job_done;
  logic          r_timeout;

  assign w_in_pair = '{mcand: s_mcand, mplier: s_mplier};

`ifdef BOOTH_FEED_SKID_EN
  operand_pair_t r_skid;
  logic          r_skid_valid;
  logic          w_accept;

  assign s_ready  = !r_skid_valid;
  assign w_accept = s_valid && s_ready;
  // A buffered pair always wins over a newly offered one.
  assign w_launch      = (r_state == IDLE) && !mult_done && (r_skid_valid || s_valid);
  assign w_launch_pair = r_skid_valid ? r_skid : w_in_pair;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid_valid <= 1'b0;
      r_skid       <= '0;
    end else if (r_skid_valid) begin
      if (w_launch) begin
        r_skid_valid <= 1'b0;
      end
    end else if (w_accept && !w_launch) begin
      r_skid_valid <= 1'b1;
      r_skid       <= w_in_pair;
    end
  end
`else
  assign s_ready       = (r_state == IDLE) && !mult_done;
  assign w_launch      = s_valid && s_ready;
  assign w_launch_pair = w_in_pair;
`endif

  booth_watchdog u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_launch),
    .i_enable (r_state == WAIT_DONE),
    .o_hit    (w_wd_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_next         = r_state;
    start          = 1'b0;
    data_in        = '0;
    w_job_done_set = 1'b0;
    w_timeout_set  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_launch) begin
          w_next = START;
        end
      end
      START: begin
        start  = 1'b1;
        w_next = LOAD_M;
      end
      LOAD_M: begin
        data_in = r_op.mcand;
        w_next  = LOAD_Q;
      end
      LOAD_Q: begin
        data_in = r_op.mplier;
        w_next  = WAIT_DONE;
      end
      WAIT_DONE: begin
        data_in = r_op.mplier;
        // A real completion takes priority over a watchdog hit on the same cycle.
        if (mult_done) begin
          w_job_done_set = 1'b1;
          w_next         = WAIT_CLR;
        end else if (w_wd_hit) begin
          w_timeout_set = 1'b1;
          w_next        = WAIT_CLR;
        end
      end
      WAIT_CLR: begin
        if (!mult_done) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // NOTE: the operand registers are reset even though their value is only read
  // after a launch, so data_in and internal state are fully defined out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op <= '0;
    end else if (w_launch) begin
      r_op <= w_launch_pair;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_job_done <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_job_done <= w_job_done_set;
      if (w_timeout_set) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign job_done = r_job_done;
  assign timeout  = r_timeout;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_booth_operand_feeder.sv
// Self-checking bench for booth_operand_feeder: directed sequences plus a
// scoreboard of accepted pairs compared against the operand bus after each start.
module tb_booth_operand_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [15:0] s_mcand = '0;
  logic [15:0] s_mplier = '0;
  logic        s_ready;
  logic        start;
  logic [15:0] data_in;
  logic        mult_done = 1'b0;
  logic        job_done;
  logic        timeout;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;
  int n_start = 0;
  int n_job_done = 0;

  typedef struct {
    logic [15:0] mc;
    logic [15:0] mp;
  } exp_t;
  exp_t sb_q[$];

  booth_operand_feeder dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_mcand   (s_mcand),
    .s_mplier  (s_mplier),
    .s_ready   (s_ready),
    .start     (start),
    .data_in   (data_in),
    .mult_done (mult_done),
    .job_done  (job_done),
    .timeout   (timeout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers a pair and returns on the cycle after the handshake edge.
  task automatic send(input logic [15:0] mc, input logic [15:0] mp);
    bit ok;
    ok       = 1'b0;
    s_valid  = 1'b1;
    s_mcand  = mc;
    s_mplier = mp;
    for (int i = 0; i < 200; i++) begin
      if (s_ready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    s_valid = 1'b0;
    check("send_accept", 32'(ok), 32'd1);
  endtask

  // From a WAIT_DONE cycle: raise done for two cycles, drop it, return in IDLE.
  task automatic finish_from_wait();
    mult_done = 1'b1;
    tick();
    tick();
    mult_done = 1'b0;
    tick();
  endtask

  // Scoreboard: push on every handshake, pop on start, compare the bus
  // on the two following cycles.
  initial begin
    int   phase;
    exp_t cur;
    phase = 0;
    cur   = '{mc: '0, mp: '0};
    forever begin
      @(negedge clk);
      if (rst) begin
        phase = 0;
        sb_q.delete();
      end else begin
        if (job_done) n_job_done++;
        case (phase)
          1: begin
            check("sb_mcand", 32'(data_in), 32'(cur.mc));
            phase = 2;
          end
          2: begin
            check("sb_mplier", 32'(data_in), 32'(cur.mp));
            phase = 0;
          end
          default: phase = 0;
        endcase
        if (start) begin
          n_start++;
          check("sb_start_bus", 32'(data_in), 32'd0);
          if (sb_q.size() == 0) begin
            check("sb_underflow", 32'(sb_q.size()), 32'd1);
          end else begin
            cur   = sb_q.pop_front();
            phase = 1;
          end
        end
        if (s_valid && s_ready) sb_q.push_back('{mc: s_mcand, mp: s_mplier});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int st0;
    int jd0;

    // Reset state
    tick();
    tick();
    check("rst_start", 32'(start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data_in", 32'(data_in), 32'd0);
    check("rst_job_done", 32'(job_done), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    rst = 1'b0;
    tick();
    check("post_rst_s_ready", 32'(s_ready), 32'd1);

    // Test 1: (3, -5) -> start, 3, 0xFFFB, done after 20 cycles
    send(16'd3, 16'hFFFB);
    check("t1_start", 32'(start), 32'd1);
    check("t1_start_bus", 32'(data_in), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    check("t1_start_one_cycle", 32'(start), 32'd0);
    check("t1_mcand", 32'(data_in), 32'd3);
    tick();
    check("t1_mplier", 32'(data_in), 32'hFFFB);
    tick();
    check("t1_wait_hold", 32'(data_in), 32'hFFFB);
    jd0 = n_job_done;
    st0 = n_start;
    repeat (17) tick();
    check("t1_no_early_done", 32'(job_done), 32'd0);
    mult_done = 1'b1;

    // Test 2: done held for 5 cycles, next pair waits until it falls
    s_valid  = 1'b1;
    s_mcand  = 16'd10;
    s_mplier = 16'd20;
    tick();
    check("t1_job_done_pulse", 32'(job_done), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
`ifndef BOOTH_FEED_SKID_EN
      check("t2_ready_low_while_done", 32'(s_ready), 32'd0);
`endif
    end
    tick();
    check("t1_job_done_count", 32'(n_job_done - jd0), 32'd1);
    check("t2_no_start_while_done", 32'(n_start - st0), 32'd0);
    mult_done = 1'b0;
    tick();
    check("t2_idle_after_clear", 32'(busy), 32'd0);
    check("t2_no_start_yet", 32'(start), 32'd0);
    tick();
    s_valid = 1'b0;
    check("t2_start_after_fall", 32'(start), 32'd1);
    repeat (3) tick();
    finish_from_wait();
    tick();
    check("t2_back_idle", 32'(busy), 32'd0);

    // Test 3: done never arrives -> timeout at watchdog 96
    jd0 = n_job_done;
    send(16'h0101, 16'h0202);
    check("t3_start", 32'(start), 32'd1);
    repeat (99) tick();
    check("t3_no_timeout_yet", 32'(timeout), 32'd0);
    check("t3_still_waiting", 32'(data_in), 32'h0202);
    tick();
    check("t3_timeout_set", 32'(timeout), 32'd1);
    check("t3_wait_clr_busy", 32'(busy), 32'd1);
    check("t3_wait_clr_bus", 32'(data_in), 32'd0);
    tick();
    check("t3_idle_after", 32'(busy), 32'd0);
    check("t3_timeout_sticky", 32'(timeout), 32'd1);
    check("t3_no_job_done", 32'(n_job_done - jd0), 32'd0);

    // Test 4: reset during LOAD_M, then a normal job
    send(16'd5, 16'd6);
    tick();
    check("t4_load_m", 32'(data_in), 32'd5);
    #1;
    rst = 1'b1;
    #1;
    check("t4_rst_start", 32'(start), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_data_in", 32'(data_in), 32'd0);
    check("t4_rst_timeout", 32'(timeout), 32'd0);
    check("t4_rst_job_done", 32'(job_done), 32'd0);
    check("t4_rst_s_ready", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    jd0 = n_job_done;
    send(16'd11, 16'd13);
    check("t4_restart", 32'(start), 32'd1);
    tick();
    check("t4_mcand", 32'(data_in), 32'd11);
    tick();
    check("t4_mplier", 32'(data_in), 32'd13);
    tick();
    finish_from_wait();
    check("t4_job_done_count", 32'(n_job_done - jd0), 32'd1);

    // Test 6: inputs change after acceptance
    send(16'h00AA, 16'h0055);
    s_mcand  = 16'h1234;
    s_mplier = 16'hBEEF;
    tick();
    check("t6_captured_mcand", 32'(data_in), 32'h00AA);
    tick();
    check("t6_captured_mplier", 32'(data_in), 32'h0055);
    tick();
    finish_from_wait();

`ifdef BOOTH_FEED_SKID_EN
    // Test 5: second pair buffered during WAIT_DONE
    send(16'd1, 16'd2);
    repeat (3) tick();
    s_valid  = 1'b1;
    s_mcand  = 16'd7;
    s_mplier = 16'd9;
    check("t5_ready_while_busy", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    check("t5_ready_full", 32'(s_ready), 32'd0);
    mult_done = 1'b1;
    tick();
    tick();
    mult_done = 1'b0;
    tick();
    check("t5_idle_gap", 32'(start), 32'd0);
    tick();
    check("t5_buffered_start", 32'(start), 32'd1);
    tick();
    check("t5_mcand", 32'(data_in), 32'd7);
    tick();
    check("t5_mplier", 32'(data_in), 32'd9);
    check("t5_ready_drained", 32'(s_ready), 32'd1);
    tick();
    finish_from_wait();
`else
    // Offer withdrawn while blocked by done: nothing happens
    st0 = n_start;
    mult_done = 1'b1;
    s_valid   = 1'b1;
    s_mcand   = 16'd99;
    tick();
    s_valid   = 1'b0;
    tick();
    mult_done = 1'b0;
    repeat (3) tick();
    check("t7_withdrawn_busy", 32'(busy), 32'd0);
    check("t7_withdrawn_no_start", 32'(n_start - st0), 32'd0);
`endif

    tick();
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_operand_feeder.md
BOOTH_OPERAND_FEEDER -- requirements
Module: booth_operand_feeder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset named `clk` and `rst`.
REQ-002 Port `clk` SHALL be an input, 1 bit wide, and be the rising-edge clock for all state.
REQ-003 Port `rst` SHALL be an input, 1 bit wide, and be an asynchronous, active-high reset.
REQ-004 Port `s_valid` SHALL be an input, 1 bit wide, and signal that an upstream operand pair is offered.
REQ-005 Port `s_mcand` SHALL be an input, 16 bits wide, and carry the multiplicand.
REQ-006 Port `s_mplier` SHALL be an input, 16 bits wide, and carry the multiplier.
REQ-007 Port `s_ready` SHALL be an output, 1 bit wide; a pair transfers on any cycle with `s_valid` && `s_ready`.
REQ-008 Port `start` SHALL be an output, 1 bit wide, and be the start pulse to the Booth controller.
REQ-009 Port `data_in` SHALL be an output, 16 bits wide, and be the shared operand bus to the Booth datapath.
REQ-010 Port `mult_done` SHALL be an input, 1 bit wide, and be the Booth controller's done level.
REQ-011 Port `job_done` SHALL be an output, 1 bit wide, and pulse for one cycle per completed job.
REQ-012 Port `timeout` SHALL be an output, 1 bit wide, and be a sticky error flag.
REQ-013 Port `busy` SHALL be an output, 1 bit wide, and be high in every state except IDLE.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, START, LOAD_M, LOAD_Q, WAIT_DONE, WAIT_CLR.
REQ-015 IDLE SHALL go to START when an operand pair is available and `mult_done` is 0; otherwise it SHALL stay in IDLE.
REQ-016 In START, `start` SHALL be 1 for exactly one cycle and `data_in` SHALL be 0; the next state SHALL be LOAD_M.
REQ-017 In LOAD_M, `data_in` SHALL equal the multiplicand, held one full cycle; the next state SHALL be LOAD_Q.
REQ-018 In LOAD_Q, `data_in` SHALL equal the multiplier, held one full cycle; the next state SHALL be WAIT_DONE.
REQ-019 In WAIT_DONE, `data_in` SHALL hold the multiplier; on `mult_done`=1 the block SHALL pulse `job_done` for 1 cycle and go to WAIT_CLR.
REQ-020 WAIT_CLR SHALL go to IDLE when `mult_done`=0, so a new job never starts while done is still asserted.
REQ-021 Latency from pair acceptance to `start` SHALL be 1 cycle, and from `start` to the multiplicand on `data_in` 1 cycle.
REQ-022 A 7-bit watchdog SHALL clear on entry to START and increment each cycle in WAIT_DONE.
REQ-023 When the watchdog reaches 96, the block SHALL set `timeout`, drop the job without a `job_done` pulse, and go to WAIT_CLR.
REQ-024 `timeout` SHALL stay set until reset.
REQ-025 Operands SHALL be captured into internal registers on acceptance; changes on `s_*` after acceptance SHALL NOT affect the job in flight.
REQ-026 If `s_valid` drops without a handshake, no state change SHALL result.
REQ-027 If `mult_done` rises during START, LOAD_M or LOAD_Q, the block SHALL ignore it and only sample `mult_done` in WAIT_DONE.

Reset
REQ-028 Reset SHALL take effect immediately, mid-job included, with no handshake completing on the reset cycle.
REQ-029 During and after reset: state IDLE; `start`, `job_done`, `timeout`, `busy` = 0; `data_in` = 0; watchdog 0; skid buffer empty; `s_ready` = 1.

Configuration
REQ-030 With macro `BOOTH_FEED_SKID_EN` defined, a 1-entry skid buffer SHALL be present, and `s_ready` SHALL be 1 whenever the buffer is empty, including while busy.
REQ-031 With `BOOTH_FEED_SKID_EN` defined, IDLE SHALL launch from the buffer first.
REQ-032 With `BOOTH_FEED_SKID_EN` defined, a buffered pair SHALL start 1 cycle after WAIT_CLR exits.
REQ-033 Without `BOOTH_FEED_SKID_EN`, `s_ready` SHALL equal (state == IDLE && !`mult_done`).

Structure
REQ-034 A shared package `booth_pkg` SHALL hold the operand width (16), the state encoding and the watchdog limit (96).
REQ-035 The watchdog SHALL be the sub-module `booth_watchdog` (clear, enable, limit-hit output); everything else SHALL be flat.

Verification
REQ-036 Test 1: pair (3, -5) on `s_valid` in IDLE -> `start` the next cycle, then `data_in` = 3, then `data_in` = 0xFFFB; `mult_done` raised 20 cycles later -> one `job_done` pulse.
REQ-037 Test 2: `mult_done` held high for 5 cycles after a job -> no new `start` until 1 cycle after it falls.
REQ-038 Test 3: `mult_done` never asserts -> `timeout` = 1 at watchdog count 96, no `job_done`, FSM in WAIT_CLR.
REQ-039 Test 4: `rst` asserted during LOAD_M -> all outputs zero immediately; the next pair is processed normally.
REQ-040 Test 5 (skid enabled): second pair (7, 9) offered during WAIT_DONE -> accepted at once, `s_ready` = 0, `data_in` = 7 then 9 after the first job clears.
REQ-041 Test 6: `s_mcand` changed to 0x1234 after acceptance -> `data_in` still shows the captured value.
